// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - shared types and constants for the animation sequencer and object modules
// Contents:
//   anim_state_t  sequencer states IDLE / WAIT / UPDATE / RESTART
//   N_OBJ_MAX     upper bound on sequenced objects
//   D_WIDTH/D_HEIGHT  visible display size used by the object modules
//   next_en()     lowest set mask bit at or above a start index
package anim_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        UPDATE  = 2'd2,
        RESTART = 2'd3
    } anim_state_t;

    localparam int N_OBJ_MAX = 16;
    localparam int D_WIDTH   = 640;
    localparam int D_HEIGHT  = 480;

    // Returns {1'b0, index} of the lowest set bit of m at or above 'from',
    // or 5'h10 when no such bit exists (sweep finished / empty mask).
    function automatic logic [4:0] next_en(input logic [N_OBJ_MAX-1:0] m, input int from);
        logic [4:0] r;
        r = 5'h10;
        for (int i = N_OBJ_MAX - 1; i >= 0; i--) begin
            if (i >= from && m[i]) begin
                r = {1'b0, 4'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_divider.sv
// rtl/frame_divider.sv - frame-strobe divider deciding when an update sweep is due
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_clr         clear the divider count (global restart)
//   i_tick        a frame strobe was consumed while running
//   i_speed       frames per update minus 1
//   o_upd_due     current count has reached i_speed
module frame_divider #(
    parameter int SPD_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic [SPD_W-1:0] i_speed,
    output logic             o_upd_due
);

    logic [SPD_W-1:0] div_cnt_q;
    logic [SPD_W-1:0] div_cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // >= rather than == so that lowering i_speed below the current count
    // fires on the next frame instead of waiting for a wrap.
    always_comb begin
        o_upd_due = (div_cnt_q >= i_speed);
        div_cnt_d = div_cnt_q;
        if (i_clr) begin
            div_cnt_d = '0;
        end else if (i_tick) begin
            div_cnt_d = o_upd_due ? '0 : div_cnt_q + SPD_W'(1);
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// rtl/anim_sequencer.sv - turns the VGA frame strobe into per-object one-hot animate strobes
// Optional feature: define ANIM_SEQ_MASK_EN to add i_obj_en (per-object enable mask,
// sampled at sweep start; disabled objects take no strobe and no cycle).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_frame_stb    frame strobe (start of vertical blanking)
//   i_run          1 = free-run, 0 = paused
//   i_step         request one update while paused
//   i_restart      return all objects to their initial position
//   i_speed        frames per update minus 1
//   o_ani_stb      one-hot animate strobe, bit k -> object k
//   o_obj_rst      one-cycle reset to all objects
//   o_busy         sweeping or restarting
//   o_overrun      sticky: frame strobe seen mid-sweep
//   o_upd_cnt      completed sweeps, wrapping
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int N_OBJ = 4,
    parameter int SPD_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_frame_stb,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_restart,
    input  logic [SPD_W-1:0] i_speed,
`ifdef ANIM_SEQ_MASK_EN
    input  logic [N_OBJ-1:0] i_obj_en,
`endif
    output logic [N_OBJ-1:0] o_ani_stb,
    output logic             o_obj_rst,
    output logic             o_busy,
    output logic             o_overrun,
    output logic [CNT_W-1:0] o_upd_cnt
);

    anim_state_t            state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [N_OBJ_MAX-1:0]   mask_q, mask_d;
    logic [N_OBJ-1:0]       ani_stb_q, ani_stb_d;
    logic                   step_pend_q, step_pend_d;
    logic                   overrun_q, overrun_d;
    logic [CNT_W-1:0]       upd_cnt_q, upd_cnt_d;

    logic [N_OBJ_MAX-1:0]   mask_src;
    logic [4:0]             sel_first;
    logic [4:0]             sel_next;
    logic                   div_tick;
    logic                   upd_due;

`ifdef ANIM_SEQ_MASK_EN
    assign mask_src = N_OBJ_MAX'(i_obj_en);
`else
    assign mask_src = N_OBJ_MAX'({N_OBJ{1'b1}});
`endif

    frame_divider #(.SPD_W(SPD_W)) u_div (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (i_restart),
        .i_tick    (div_tick),
        .i_speed   (i_speed),
        .o_upd_due (upd_due)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            mask_q      <= '0;
            ani_stb_q   <= '0;
            step_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            upd_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            ani_stb_q   <= ani_stb_d;
            step_pend_q <= step_pend_d;
            overrun_q   <= overrun_d;
            upd_cnt_q   <= upd_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        ani_stb_d   = '0;
        step_pend_d = step_pend_q;
        overrun_d   = overrun_q;
        upd_cnt_d   = upd_cnt_q;
        div_tick    = 1'b0;
        sel_first   = next_en(mask_src, 0);
        sel_next    = next_en(mask_q, int'(idx_q) + 1);

        if (i_restart) begin
            state_d     = RESTART;
            step_pend_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_frame_stb && step_pend_q) begin
                        step_pend_d = 1'b0;
                        state_d     = UPDATE;
                    end else begin
                        if (i_step) step_pend_d = 1'b1;
                        if (i_run)  state_d     = WAIT;
                    end
                end
                WAIT: begin
                    if (i_frame_stb) begin
                        div_tick = 1'b1;
                        if (upd_due)     state_d = UPDATE;
                        else if (!i_run) state_d = IDLE;
                    end else if (!i_run) begin
                        state_d = IDLE;
                    end
                end
                UPDATE: begin
                    if (i_frame_stb) overrun_d = 1'b1;
                    if (sel_next[4]) begin
                        state_d   = i_run ? WAIT : IDLE;
                        upd_cnt_d = upd_cnt_q + CNT_W'(1);
                    end else begin
                        idx_d     = sel_next[3:0];
                        ani_stb_d = N_OBJ'(1) << sel_next[3:0];
                    end
                end
                default: begin
                    state_d = i_run ? WAIT : IDLE;
                end
            endcase

            // Sweep entry: latch the mask and emit the first strobe on the
            // same edge so object 0 fires the cycle after the frame strobe.
            // An empty mask gives one strobe-less UPDATE cycle.
            if (state_q != UPDATE && state_d == UPDATE) begin
                mask_d    = mask_src;
                idx_d     = sel_first[3:0];
                ani_stb_d = sel_first[4] ? '0 : N_OBJ'(1) << sel_first[3:0];
            end
        end
    end

    always_comb begin
        o_ani_stb = ani_stb_q;
        o_obj_rst = (state_q == RESTART);
        o_busy    = (state_q == UPDATE) || (state_q == RESTART);
        o_overrun = overrun_q;
        o_upd_cnt = upd_cnt_q;
    end

endmodule

// File: tb/tb_anim_sequencer.sv
// tb/tb_anim_sequencer.sv - self-checking bench for anim_sequencer against a behavioural model
module tb_anim_sequencer;

    localparam int N = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_frame_stb = 1'b0;
    logic        i_run = 1'b0;
    logic        i_step = 1'b0;
    logic        i_restart = 1'b0;
    logic [3:0]  i_speed = 4'd0;
    logic [N-1:0] i_obj_en = '1;
    logic [N-1:0] o_ani_stb;
    logic        o_obj_rst;
    logic        o_busy;
    logic        o_overrun;
    logic [15:0] o_upd_cnt;

    int n_chk = 0;
    int n_pass = 0;

    anim_sequencer dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_frame_stb (i_frame_stb),
        .i_run       (i_run),
        .i_step      (i_step),
        .i_restart   (i_restart),
        .i_speed     (i_speed),
`ifdef ANIM_SEQ_MASK_EN
        .i_obj_en    (i_obj_en),
`endif
        .o_ani_stb   (o_ani_stb),
        .o_obj_rst   (o_obj_rst),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun),
        .o_upd_cnt   (o_upd_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: a sweep is a queue of strobe words, one per cycle.
    bit          m_paused = 1'b1;
    bit          m_sweep = 1'b0;
    bit          m_rstc = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_ovr = 1'b0;
    int          m_div = 0;
    int          m_cnt = 0;
    logic [N-1:0] m_ani = '0;
    int          sweep_q[$];

    function automatic void start_sweep();
        logic [N-1:0] msk;
`ifdef ANIM_SEQ_MASK_EN
        msk = i_obj_en;
`else
        msk = '1;
`endif
        sweep_q.delete();
        for (int k = 0; k < N; k++) if (msk[k]) sweep_q.push_back(1 << k);
        if (sweep_q.size() == 0) sweep_q.push_back(0);
        m_ani   = N'(sweep_q.pop_front());
        m_sweep = 1'b1;
    endfunction

    function automatic void model_step();
        m_ani = '0;
        if (i_rst) begin
            m_paused = 1'b1; m_sweep = 1'b0; m_rstc = 1'b0;
            m_pend = 1'b0; m_ovr = 1'b0; m_div = 0; m_cnt = 0;
            sweep_q.delete();
        end else if (i_restart) begin
            m_rstc = 1'b1; m_sweep = 1'b0; sweep_q.delete();
            m_div = 0; m_pend = 1'b0; m_ovr = 1'b0;
        end else if (m_sweep) begin
            if (i_frame_stb) m_ovr = 1'b1;
            if (sweep_q.size() == 0) begin
                m_sweep  = 1'b0;
                m_cnt    = (m_cnt + 1) % 65536;
                m_paused = !i_run;
            end else begin
                m_ani = N'(sweep_q.pop_front());
            end
        end else if (m_rstc) begin
            m_rstc   = 1'b0;
            m_paused = !i_run;
        end else if (m_paused) begin
            if (i_frame_stb && m_pend) begin
                m_pend = 1'b0;
                start_sweep();
            end else begin
                if (i_step) m_pend = 1'b1;
                if (i_run)  m_paused = 1'b0;
            end
        end else begin
            if (i_frame_stb) begin
                if (m_div >= int'(i_speed)) begin
                    m_div = 0;
                    start_sweep();
                end else begin
                    m_div++;
                    if (!i_run) m_paused = 1'b1;
                end
            end else if (!i_run) begin
                m_paused = 1'b1;
            end
        end
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        model_step();
        #1;
        chk("ani_stb", 32'(o_ani_stb), 32'(m_ani));
        chk("obj_rst", 32'(o_obj_rst), 32'(m_rstc));
        chk("busy",    32'(o_busy),    32'(m_sweep || m_rstc));
        chk("overrun", 32'(o_overrun), 32'(m_ovr));
        chk("upd_cnt", 32'(o_upd_cnt), 32'(m_cnt));
    endtask

    task automatic frame_pulse();
        i_frame_stb = 1'b1; cyc(); i_frame_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    int base;

    initial begin
        // reset
        i_rst = 1'b1; idle(2); i_rst = 1'b0;
        chk("rst_ani", 32'(o_ani_stb), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_cnt", 32'(o_upd_cnt), 0);

        // 1: run, speed 0 -> one strobe per object on consecutive cycles
        i_run = 1'b1; i_speed = 4'd0; idle(3);
        frame_pulse();
        chk("t1_s0", 32'(o_ani_stb), 32'h1);
        cyc(); chk("t1_s1", 32'(o_ani_stb), 32'h2);
        cyc(); chk("t1_s2", 32'(o_ani_stb), 32'h4);
        cyc(); chk("t1_s3", 32'(o_ani_stb), 32'h8);
        cyc(); chk("t1_busy", 32'(o_busy), 0);
        chk("t1_cnt", 32'(o_upd_cnt), 1);

        // 2: speed 2 -> every third frame sweeps
        i_speed = 4'd2; idle(2); base = int'(o_upd_cnt);
        for (int f = 0; f < 6; f++) begin frame_pulse(); idle(6); end
        chk("t2_cnt", 32'(o_upd_cnt), 32'(base + 2));

        // 3: paused single-step
        i_run = 1'b0; i_speed = 4'd0; idle(2); base = int'(o_upd_cnt);
        i_step = 1'b1; cyc(); i_step = 1'b0; idle(2);
        frame_pulse(); idle(6); frame_pulse(); idle(6);
        chk("t3_cnt", 32'(o_upd_cnt), 32'(base + 1));
        chk("t3_busy", 32'(o_busy), 0);

        // 4: restart in the second sweep cycle
        i_run = 1'b1; idle(2); base = int'(o_upd_cnt);
        frame_pulse(); cyc();
        chk("t4_s1", 32'(o_ani_stb), 32'h2);
        i_restart = 1'b1; cyc(); i_restart = 1'b0;
        chk("t4_objrst", 32'(o_obj_rst), 1);
        chk("t4_ani0", 32'(o_ani_stb), 0);
        cyc();
        chk("t4_objrst_off", 32'(o_obj_rst), 0);
        chk("t4_ani_quiet", 32'(o_ani_stb), 0);
        idle(4);
        chk("t4_cnt", 32'(o_upd_cnt), 32'(base));
        chk("t4_ovr", 32'(o_overrun), 0);

        // 5: frame during a sweep -> sticky overrun, no extra sweep
        base = int'(o_upd_cnt);
        frame_pulse(); cyc(); frame_pulse(); idle(8);
        chk("t5_ovr", 32'(o_overrun), 1);
        chk("t5_cnt", 32'(o_upd_cnt), 32'(base + 1));
        idle(5);
        chk("t5_ovr_sticky", 32'(o_overrun), 1);
        i_restart = 1'b1; cyc(); i_restart = 1'b0; cyc();
        chk("t5_ovr_clr", 32'(o_overrun), 0);

`ifdef ANIM_SEQ_MASK_EN
        // 6: masked sweep and empty mask
        i_obj_en = 4'b0101; idle(2);
        frame_pulse(); chk("t6_s0", 32'(o_ani_stb), 32'h1);
        cyc(); chk("t6_s1", 32'(o_ani_stb), 32'h4);
        idle(3); base = int'(o_upd_cnt);
        i_obj_en = 4'b0000;
        frame_pulse(); chk("t6_empty_ani", 32'(o_ani_stb), 0);
        chk("t6_empty_busy", 32'(o_busy), 1);
        cyc(); chk("t6_empty_cnt", 32'(o_upd_cnt), 32'(base + 1));
        i_obj_en = '1;
`endif

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            i_frame_stb = ($urandom_range(0, 5) == 0);
            i_step      = ($urandom_range(0, 9) == 0);
            i_restart   = ($urandom_range(0, 59) == 0);
            i_rst       = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 29) == 0) i_run = ~i_run;
            if ($urandom_range(0, 99) == 0) i_speed = 4'($urandom_range(0, 3));
`ifdef ANIM_SEQ_MASK_EN
            if ($urandom_range(0, 19) == 0) i_obj_en = N'($urandom);
`endif
            cyc();
        end
        i_frame_stb = 1'b0; i_step = 1'b0; i_restart = 1'b0; i_rst = 1'b0;
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
